// File: rtl/ntt_addr_gen_pkg.sv
// Shared NTT address-generator constants and FSM state encoding.
// Pure declarations: no logic, no latency, no flow control.
package ntt_addr_gen_pkg;

  localparam int LOG_N_DEF    = 9;
  localparam int N_DEF        = 1 << LOG_N_DEF;
  localparam int PIPE_LAT_DEF = 11;
  localparam int ADDR_W_DEF   = 2 * LOG_N_DEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GAP   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/ntt_bf_addr_map.sv
// Butterfly (bf, stage) -> {a, b, twiddle} index map for an in-place radix-2 NTT.
// Purely combinational, zero latency, no flow control.
module ntt_bf_addr_map
  import ntt_addr_gen_pkg::*;
#(
  parameter int LOG_N = LOG_N_DEF,
  parameter int SW    = $clog2(LOG_N_DEF)
) (
  input  logic [LOG_N-2:0] bf_i,
  input  logic [SW-1:0]    stage_i,
  output logic [LOG_N-1:0] a_o,
  output logic [LOG_N-1:0] b_o,
  output logic [LOG_N-2:0] twid_o
);

  logic [LOG_N-1:0] bf_ext;
  logic [LOG_N-1:0] m;
  logic [LOG_N-1:0] lo;
  logic [LOG_N-1:0] a;
  logic [SW-1:0]    tw_sh;

  always_comb begin
    bf_ext = {1'b0, bf_i};
    m      = LOG_N'(1) << stage_i;
    lo     = bf_ext & (m - LOG_N'(1));
    // Group index moves up one bit to open the hole where the partner's m-bit sits.
    a      = (((bf_ext >> stage_i) << stage_i) << 1) | lo;
    tw_sh  = SW'(LOG_N - 1) - stage_i;
    a_o    = a;
    b_o    = a | m;
    twid_o = lo[LOG_N-2:0] << tw_sh;
  end

endmodule

// File: rtl/ntt_addr_gen.sv
// NTT read-address/twiddle sequencer; PIPE_LAT-cycle bubbles between stages and before done.
// First pair registered one clken edge after start; clken=0 freezes all state and outputs.
module ntt_addr_gen
  import ntt_addr_gen_pkg::*;
#(
  parameter int LOG_N    = LOG_N_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clken,
  input  logic                 start,
  output logic [2*LOG_N-1:0]   addr_o,
  output logic [LOG_N-2:0]     twid_o,
  output logic                 addr_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = $clog2(LOG_N);
  localparam int BW = LOG_N - 1;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [BW-1:0] BF_LAST    = '1;
  localparam logic [SW-1:0] STAGE_LAST = SW'(LOG_N - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PIPE_LAT - 1);

  state_e               state_q, state_d;
  logic [BW-1:0]        bf_q, bf_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*LOG_N-1:0]   addr_q, addr_d;
  logic [LOG_N-2:0]     twid_q, twid_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [LOG_N-1:0]     map_a, map_b;
  logic [LOG_N-2:0]     map_tw;

  // Mapped from the next bf/stage so the output registers load in the same edge as the FSM.
  ntt_bf_addr_map #(.LOG_N(LOG_N), .SW(SW)) u_map (
    .bf_i    (bf_d),
    .stage_i (stage_d),
    .a_o     (map_a),
    .b_o     (map_b),
    .twid_o  (map_tw)
  );

  always_comb begin
    state_d = state_q;
    bf_d    = bf_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          bf_d    = '0;
          stage_d = '0;
        end
      end
      ST_ISSUE: begin
        if (bf_q != BF_LAST) begin
          bf_d = bf_q + BW'(1);
        end else if (stage_q != STAGE_LAST) begin
          if (PIPE_LAT == 0) begin
            bf_d    = '0;
            stage_d = stage_q + SW'(1);
          end else begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end
        end else begin
          state_d = (PIPE_LAT == 0) ? ST_DONE : ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_ISSUE;
          bf_d    = '0;
          stage_d = stage_q + SW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    // Hold the last pair during bubbles so the delay line sees no toggling.
    addr_d  = valid_d ? {map_a, map_b} : addr_q;
    twid_d  = valid_d ? map_tw : twid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bf_q    <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      twid_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clken) begin
      state_q <= state_d;
      bf_q    <= bf_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      twid_q  <= twid_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign addr_o     = addr_q;
  assign twid_o     = twid_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Directed bench for ntt_addr_gen: pair sequence vs. a group/offset loop model, bubbles, clken, reset.
// Write-back timing is modelled by per-address last-issue stamps in enabled-cycle units.
module tb_ntt_addr_gen;

  localparam int LOG_N    = 9;
  localparam int N        = 512;
  localparam int HALF     = 256;
  localparam int PIPE_LAT = 11;
  localparam int TOTAL    = LOG_N * HALF;
  localparam int BUSY_EXP = TOTAL + (LOG_N - 1) * PIPE_LAT + PIPE_LAT + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clken;
  logic        start;
  logic [17:0] addr_o;
  logic [7:0]  twid_o;
  logic        addr_valid;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ntt_addr_gen #(.LOG_N(LOG_N), .PIPE_LAT(PIPE_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clken      (clken),
    .start      (start),
    .addr_o     (addr_o),
    .twid_o     (twid_o),
    .addr_valid (addr_valid),
    .busy       (busy),
    .done       (done)
  );

  int tests = 0;
  int fails = 0;

  int exp_a[TOTAL], exp_b[TOTAL], exp_t[TOTAL];
  int got_a[TOTAL], got_b[TOTAL], got_t[TOTAL];
  int issue_cyc[TOTAL];
  int last_wr[N];
  int touched[N];
  int n_pairs, n_busy, n_done, n_frozen, n_hazard, n_dup, n_badpair, done_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr"},  32'(addr_o),     0);
    chk({tag, "_twid"},  32'(twid_o),     0);
    chk({tag, "_valid"}, 32'(addr_valid), 0);
    chk({tag, "_busy"},  32'(busy),       0);
    chk({tag, "_done"},  32'(done),       0);
  endtask

  task automatic run_xform(input int drop_pct, input bit poke, input int abort_idx);
    int ecyc, stg, a, b;
    bit en_prev, done_prev, finished;
    logic [28:0] snap;
    n_pairs = 0; n_busy = 0; n_done = 0; n_frozen = 0;
    n_hazard = 0; n_dup = 0; n_badpair = 0; done_cyc = -1;
    for (int i = 0; i < N; i++) begin
      last_wr[i] = -1000;
      touched[i] = -1;
    end
    for (int i = 0; i < TOTAL; i++) begin
      got_a[i] = -1; got_b[i] = -1; got_t[i] = -1; issue_cyc[i] = -1;
    end
    ecyc = 0; done_prev = 0; finished = 0; snap = '0;
    clken = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; en_prev = 1'b1;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      if (en_prev) begin
        ecyc++;
        if (done_prev) begin
          chk("busy_falls_after_done", 32'(busy), 0);
          finished = 1;
        end else begin
          if (busy) n_busy++;
          if (done) begin
            n_done++;
            done_cyc = ecyc;
          end
          done_prev = done;
          if (addr_valid && n_pairs < TOTAL) begin
            a = int'(addr_o[17:9]);
            b = int'(addr_o[8:0]);
            got_a[n_pairs] = a;
            got_b[n_pairs] = b;
            got_t[n_pairs] = int'(twid_o);
            issue_cyc[n_pairs] = ecyc;
            if (a != exp_a[n_pairs] || b != exp_b[n_pairs] || int'(twid_o) != exp_t[n_pairs])
              n_badpair++;
            stg = n_pairs / HALF;
            if (touched[a] == stg || touched[b] == stg || a == b) n_dup++;
            if (ecyc - last_wr[a] <= PIPE_LAT || ecyc - last_wr[b] <= PIPE_LAT) n_hazard++;
            touched[a] = stg; touched[b] = stg;
            last_wr[a] = ecyc; last_wr[b] = ecyc;
            n_pairs++;
          end
        end
      end else if ({addr_o, twid_o, addr_valid, busy, done} !== snap) begin
        n_frozen++;
      end
      snap = {addr_o, twid_o, addr_valid, busy, done};
      if (finished) break;
      if (n_pairs == abort_idx) begin
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        clken = 1'b1;
        start = 1'b0;
        return;
      end
      clken = ($urandom_range(99) >= drop_pct);
      start = 1'b0;
      if (poke && busy && (n_pairs == 3 * HALF + 10 || (n_pairs == 5 * HALF && !addr_valid))) begin
        clken = 1'b1;
        start = 1'b1;
      end
      en_prev = clken;
      @(posedge clk); #1;
    end
    start = 1'b0;
    clken = 1'b1;
    if (!finished) chk("run_completed_in_budget", 0, 1);
  endtask

  initial begin
    int k;
    k = 0;
    for (int s = 0; s < LOG_N; s++) begin
      for (int g = 0; g < HALF >> s; g++) begin
        for (int j = 0; j < (1 << s); j++) begin
          exp_a[k] = g * (2 << s) + j;
          exp_b[k] = exp_a[k] + (1 << s);
          exp_t[k] = j * (HALF >> s);
          k++;
        end
      end
    end

    rst_n = 1'b1; clken = 1'b0; start = 1'b0;
    #1 rst_n = 1'b0;
    #2 chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // start with clken low must not be latched
    start = 1'b1; clken = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b0; clken = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("gated_start_busy",  32'(busy),       0);
    chk("gated_start_valid", 32'(addr_valid), 0);

    // full run, clken always high
    run_xform(0, 1'b0, -1);
    chk("run1_pairs",      n_pairs,   TOTAL);
    chk("run1_busy_cycles", n_busy,   BUSY_EXP);
    chk("run1_done_pulses", n_done,   1);
    chk("run1_golden",     n_badpair, 0);
    chk("run1_hazard",     n_hazard,  0);
    chk("run1_dup",        n_dup,     0);
    chk("first_issue_cycle", issue_cyc[0], 1);
    chk("p0_a",   got_a[0], 0);   chk("p0_b",   got_b[0], 1);   chk("p0_t",   got_t[0], 0);
    chk("p1_a",   got_a[1], 2);   chk("p1_b",   got_b[1], 3);
    chk("p255_a", got_a[255], 510); chk("p255_b", got_b[255], 511);
    chk("s1p0_a", got_a[256], 0); chk("s1p0_b", got_b[256], 2); chk("s1p0_t", got_t[256], 0);
    chk("s1p1_a", got_a[257], 1); chk("s1p1_b", got_b[257], 3); chk("s1p1_t", got_t[257], 128);
    chk("s1p2_a", got_a[258], 4); chk("s1p2_b", got_b[258], 6); chk("s1p2_t", got_t[258], 0);
    chk("last_a", got_a[TOTAL-1], 255); chk("last_b", got_b[TOTAL-1], 511);
    chk("last_t", got_t[TOTAL-1], 255);
    chk("stage_gap", issue_cyc[256] - issue_cyc[255], PIPE_LAT + 1);
    chk("flush_to_done", done_cyc - issue_cyc[TOTAL-1], PIPE_LAT + 1);

    // ~30% clken dropouts plus ignored start pulses in stage 3 ISSUE and in a GAP
    run_xform(30, 1'b1, -1);
    chk("run2_pairs",       n_pairs,   TOTAL);
    chk("run2_busy_cycles", n_busy,    BUSY_EXP);
    chk("run2_done_pulses", n_done,    1);
    chk("run2_golden",      n_badpair, 0);
    chk("run2_frozen",      n_frozen,  0);
    chk("run2_hazard",      n_hazard,  0);

    // reset mid stage 4
    run_xform(0, 1'b0, 4 * HALF + 50);
    chk("abort_no_done", n_done, 0);
    repeat (2) @(posedge clk);
    #1 chk_zero_outputs("held_reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_reset_idle_busy", 32'(busy), 0);

    run_xform(0, 1'b0, -1);
    chk("run4_pairs",       n_pairs,   TOTAL);
    chk("run4_done_pulses", n_done,    1);
    chk("run4_golden",      n_badpair, 0);
    chk("run4_p0_a", got_a[0], 0);
    chk("run4_p0_b", got_b[0], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
